// File: rtl/axi_mem_wr_slave.sv
// AXI3 write slave: one AW/W burst at a time, per-beat FIXED/INCR/WRAP addressing, one B per burst.
// Optional macro AXI_WR_PROTO_CHK_EN adds wid/wlast checking into bresp.
module axi_mem_wr_slave #(
  parameter int MEM_DEPTH = 128,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          awvalid,
  output logic          awready,
  input  logic [3:0]    awid,
  input  logic [3:0]    awlen,
  input  logic [2:0]    awsize,
  input  logic [31:0]   awaddr,
  input  logic [1:0]    awburst,
  input  logic          wvalid,
  output logic          wready,
  input  logic [3:0]    wid,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          wlast,
  input  logic          bready,
  output logic          bvalid,
  output logic [3:0]    bid,
  output logic [1:0]    bresp,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

  state_t      state;
  logic [3:0]  id_q;
  logic [3:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [31:0] cur_addr;
  logic [3:0]  beat_cnt;
  logic        cfg_err;
  logic        proto_err;
  logic        dec_err;

  logic        beat;
  logic        beat_bad;
  logic        last_beat;
  logic        beat_proto_err;
  logic        aw_cfg_bad;
  logic        dec_nxt;
  logic        proto_nxt;
  logic [1:0]  resp_nxt;
  logic [31:0] step;
  logic [31:0] bound;
  logic [31:0] next_addr;

  assign beat      = wvalid & wready;
  assign beat_bad  = cur_addr >= MEM_BYTES;
  assign last_beat = beat_cnt == len_q;

  // A burst with an illegal AW configuration never touches memory.
  assign mem_we    = beat & ~beat_bad & ~cfg_err;
  assign mem_addr  = cur_addr[AW+1:2];
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;

  assign aw_cfg_bad = (awsize > 3'd2) || (awburst == 2'd3) ||
                      ((awburst == 2'd2) && !(awlen inside {4'd1, 4'd3, 4'd7, 4'd15}));

`ifdef AXI_WR_PROTO_CHK_EN
  assign beat_proto_err = (wid != id_q) || (wlast != last_beat);
`else
  logic unused_proto;
  assign unused_proto   = ^{wid, wlast};
  assign beat_proto_err = 1'b0;
`endif

  assign step  = 32'd1 << size_q;
  assign bound = ({28'd0, len_q} + 32'd1) << size_q;

  always_comb begin
    next_addr = cur_addr + step;
    case (burst_q)
      2'd0:    next_addr = cur_addr;
      2'd2:    next_addr = (cur_addr & ~(bound - 32'd1)) | ((cur_addr + step) & (bound - 32'd1));
      default: next_addr = cur_addr + step;
    endcase
  end

  // Flags including the current beat, so the final beat is reflected in bresp.
  assign dec_nxt   = dec_err | beat_bad;
  assign proto_nxt = proto_err | beat_proto_err;
  assign resp_nxt  = dec_nxt ? 2'd3 : ((cfg_err | proto_nxt) ? 2'd2 : 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= 4'd0;
      bresp     <= 2'd0;
      id_q      <= 4'd0;
      len_q     <= 4'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'd0;
      cur_addr  <= 32'd0;
      beat_cnt  <= 4'd0;
      cfg_err   <= 1'b0;
      proto_err <= 1'b0;
      dec_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awvalid && awready) begin
            id_q      <= awid;
            len_q     <= awlen;
            size_q    <= awsize;
            burst_q   <= awburst;
            cur_addr  <= awaddr;
            beat_cnt  <= 4'd0;
            cfg_err   <= aw_cfg_bad;
            proto_err <= 1'b0;
            dec_err   <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            cur_addr  <= next_addr;
            beat_cnt  <= beat_cnt + 4'd1;
            dec_err   <= dec_nxt;
            proto_err <= proto_nxt;
            if (last_beat) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= resp_nxt;
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          awready <= 1'b1;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_wr_slave.sv
// Directed bench for axi_mem_wr_slave: burst addressing, range/config errors, B backpressure, reset.
module tb_axi_mem_wr_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [3:0]  awid, awlen;
  logic [2:0]  awsize;
  logic [31:0] awaddr;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bready, bvalid;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef AXI_WR_PROTO_CHK_EN
  localparam logic [1:0] T6_RESP = 2'd2;
`else
  localparam logic [1:0] T6_RESP = 2'd0;
`endif

  axi_mem_wr_slave #(.MEM_DEPTH(128), .AW(7)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awaddr(awaddr), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bid(bid), .bresp(bresp),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [3:0] len, input logic [2:0] size,
                       input logic [31:0] addr, input logic [1:0] burst);
    awvalid = 1'b1; awid = id; awlen = len; awsize = size; awaddr = addr; awburst = burst;
    @(negedge clk);
    chk("aw_ready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic do_beat(input logic [31:0] d, input logic [3:0] id, input logic last,
                         input logic exp_we, input logic [6:0] exp_addr);
    wvalid = 1'b1; wdata = d; wid = id; wlast = last; wstrb = 4'hF;
    @(negedge clk);
    chk("w_ready", wready, 1);
    chk("mem_we", mem_we, exp_we);
    if (exp_we) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wdata", mem_wdata, d);
      chk("mem_wstrb", mem_wstrb, 4'hF);
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_b(input logic [3:0] exp_id, input logic [1:0] exp_resp, input int hold);
    int n = 0;
    bready = 1'b0;
    while (!bvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bvalid) chk("b_timeout", 0, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("b_hold_vld", bvalid, 1);
      chk("b_hold_id", bid, exp_id);
      chk("b_hold_resp", bresp, exp_resp);
      chk("b_hold_awrdy", awready, 0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    chk("b_vld", bvalid, 1);
    chk("b_id", bid, exp_id);
    chk("b_resp", bresp, exp_resp);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("b_done_vld", bvalid, 0);
    chk("b_done_awrdy", awready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int wa[4];
    rst = 1'b1; awvalid = 1'b0; awid = 0; awlen = 0; awsize = 0; awaddr = 0; awburst = 0;
    wvalid = 1'b0; wid = 0; wdata = 0; wstrb = 0; wlast = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_mem_we", mem_we, 0);
    rst = 1'b0;

    // T1 INCR
    do_aw(4'd5, 4'd3, 3'd2, 32'h10, 2'd1);
    for (int i = 0; i < 4; i++) do_beat(32'hA0 + i, 4'd5, i == 3, 1'b1, 7'(4 + i));
    do_b(4'd5, 2'd0, 0);

    // T2 WRAP
    wa[0] = 3; wa[1] = 0; wa[2] = 1; wa[3] = 2;
    do_aw(4'd2, 4'd3, 3'd2, 32'h0C, 2'd2);
    for (int i = 0; i < 4; i++) do_beat(32'hB0 + i, 4'd2, i == 3, 1'b1, 7'(wa[i]));
    do_b(4'd2, 2'd0, 0);

    // T3 FIXED
    do_aw(4'd3, 4'd2, 3'd2, 32'h20, 2'd0);
    for (int i = 0; i < 3; i++) do_beat(32'hC0 + i, 4'd3, i == 2, 1'b1, 7'd8);
    do_b(4'd3, 2'd0, 0);

    // T4 out of range on second beat
    do_aw(4'd4, 4'd1, 3'd2, 32'h1FC, 2'd1);
    do_beat(32'hD0, 4'd4, 1'b0, 1'b1, 7'd127);
    do_beat(32'hD1, 4'd4, 1'b1, 1'b0, 7'd0);
    do_b(4'd4, 2'd3, 0);

    // T5 B backpressure
    do_aw(4'd9, 4'd0, 3'd2, 32'h0, 2'd1);
    do_beat(32'hE0, 4'd9, 1'b1, 1'b1, 7'd0);
    do_b(4'd9, 2'd0, 5);

    // T6 early wlast
    do_aw(4'd6, 4'd3, 3'd2, 32'h40, 2'd1);
    for (int i = 0; i < 4; i++) do_beat(32'hF0 + i, 4'd6, i == 2, 1'b1, 7'(16 + i));
    do_b(4'd6, T6_RESP, 0);

    // Illegal size and illegal WRAP length: no writes, SLVERR
    do_aw(4'd7, 4'd1, 3'd3, 32'h0, 2'd1);
    for (int i = 0; i < 2; i++) do_beat(32'h70 + i, 4'd7, i == 1, 1'b0, 7'd0);
    do_b(4'd7, 2'd2, 0);
    do_aw(4'd8, 4'd2, 3'd2, 32'h0, 2'd2);
    for (int i = 0; i < 3; i++) do_beat(32'h80 + i, 4'd8, i == 2, 1'b0, 7'd0);
    do_b(4'd8, 2'd2, 0);

    // T7 mid-burst reset
    do_aw(4'd1, 4'd3, 3'd2, 32'h0, 2'd1);
    do_beat(32'h90, 4'd1, 1'b0, 1'b1, 7'd0);
    do_beat(32'h91, 4'd1, 1'b0, 1'b1, 7'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t7_awready", awready, 1);
    chk("t7_wready", wready, 0);
    chk("t7_bvalid", bvalid, 0);
    wvalid = 1'b1; wdata = 32'h92; wid = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t7_idle_we", mem_we, 0);
      chk("t7_idle_bvalid", bvalid, 0);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;

    // Recovery burst after reset
    do_aw(4'd10, 4'd0, 3'd2, 32'h8, 2'd1);
    do_beat(32'h99, 4'd10, 1'b1, 1'b1, 7'd2);
    do_b(4'd10, 2'd0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_chk - n_fail, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
